// File: rtl/hash_io_bridge.sv
// hash_io_bridge: word-serial host port in front of a block-oriented hash core.
// Host words are packed into core blocks (first word in the MS position). The
// core digest is read back one IO_W word per fetch. Each host request gets a
// one-cycle registered ack or a one-cycle err pulse.
// Optional: define HASH_IO_BRIDGE_BUSYCNT_EN to count core-busy cycles on
// busy_cycles. Without the macro, busy_cycles is tied to 0.
module hash_io_bridge #(
    parameter int IO_W     = 16,
    parameter int BLOCK_W  = 32,
    parameter int DIGEST_W = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                load,
    input  logic                fetch,
    input  logic [IO_W-1:0]     idata,
    output logic                ack,
    output logic [IO_W-1:0]     odata,
    output logic                err,
    output logic                core_init,
    output logic                core_blk_valid,
    output logic [BLOCK_W-1:0]  core_blk,
    output logic                core_final,
    input  logic                core_busy,
    input  logic                core_dig_valid,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic [31:0]         busy_cycles
);
    localparam int WORDS  = BLOCK_W / IO_W;
    localparam int DWORDS = DIGEST_W / IO_W;
    localparam int CW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IW     = (DWORDS > 1) ? $clog2(DWORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
    localparam logic [IW-1:0] LAST_DIG  = IW'(DWORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CORE_RUN,
        FINAL_RUN,
        FETCH_OUT
    } state_t;

    state_t                         r_state;
    logic                           r_ack;
    logic                           r_err;
    logic [IO_W-1:0]                r_odata;
    logic                           r_core_init;
    logic                           r_blk_valid;
    logic                           r_final;
    logic [BLOCK_W-1:0]             r_blk;
    logic [CW-1:0]                  r_cnt;
    logic [IW-1:0]                  r_idx;
    // digest word 0 (MS IO_W bits) sits at index 0
    logic [0:DWORDS-1][IO_W-1:0]    r_dig;
    // core command (block or final) has been issued for the current run
    logic                           r_issued;
    // core_busy has been seen high since the block was issued
    logic                           r_seen_busy;
    // the request that started CORE_RUN/FINAL_RUN is still being held
    logic                           r_hold;

    logic                           w_init;
    logic                           w_load;
    logic                           w_fetch;
    logic                           w_both;
    logic                           w_held;
    logic [BLOCK_W-1:0]             w_blk_shift;
    logic [IW-1:0]                  w_idx_nxt;

    // a request is taken only while no ack is showing; init outranks the rest
    assign w_init  = init & ~r_ack;
    assign w_load  = load & ~r_ack & ~init;
    assign w_fetch = fetch & ~r_ack & ~init;
    assign w_both  = w_load & w_fetch;

    // while waiting on the core, the host keeps holding the request whose ack
    // is pending; that held request is not a new (erroneous) request
    assign w_held = r_hold & ((r_state == CORE_RUN) ? load : fetch);

    assign w_idx_nxt = (r_idx == LAST_DIG) ? '0 : r_idx + 1'b1;

    generate
        if (WORDS > 1) begin : g_shift
            assign w_blk_shift = {r_blk[BLOCK_W-IO_W-1:0], idata};
        end else begin : g_noshift
            assign w_blk_shift = idata;
        end
    endgenerate

    // host/core protocol FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_odata     <= '0;
            r_core_init <= 1'b0;
            r_blk_valid <= 1'b0;
            r_final     <= 1'b0;
            r_blk       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dig       <= '0;
            r_issued    <= 1'b0;
            r_seen_busy <= 1'b0;
            r_hold      <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_core_init <= 1'b0;
            r_blk_valid <= 1'b0;
            r_final     <= 1'b0;
            if (w_init) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_idx       <= '0;
                r_dig       <= '0;
                r_issued    <= 1'b0;
                r_seen_busy <= 1'b0;
                r_hold      <= 1'b0;
                r_core_init <= 1'b1;
                r_ack       <= 1'b1;
            end else begin
                case (r_state)
                    IDLE, COLLECT: begin
                        if (w_both || (w_fetch && r_state == COLLECT)) begin
                            r_err <= 1'b1;
                        end else if (w_load) begin
                            r_blk <= w_blk_shift;
                            if (r_cnt == LAST_WORD) begin
                                // last word: its ack waits for the core round trip
                                r_cnt       <= '0;
                                r_state     <= CORE_RUN;
                                r_issued    <= 1'b0;
                                r_seen_busy <= 1'b0;
                                r_hold      <= 1'b1;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_ack   <= 1'b1;
                                r_state <= COLLECT;
                            end
                        end else if (w_fetch) begin
                            // IDLE always has a zero word count: start finalisation
                            r_state  <= FINAL_RUN;
                            r_issued <= 1'b0;
                            r_hold   <= 1'b1;
                        end
                    end
                    CORE_RUN: begin
                        r_hold <= w_held;
                        if ((w_load && !w_held) || w_fetch) r_err <= 1'b1;
                        if (!r_issued) begin
                            if (!core_busy) begin
                                r_blk_valid <= 1'b1;
                                r_issued    <= 1'b1;
                            end
                        end else if (core_busy) begin
                            r_seen_busy <= 1'b1;
                        end else if (r_seen_busy) begin
                            r_ack       <= 1'b1;
                            r_state     <= IDLE;
                            r_issued    <= 1'b0;
                            r_seen_busy <= 1'b0;
                            r_hold      <= 1'b0;
                        end
                    end
                    FINAL_RUN: begin
                        r_hold <= w_held;
                        if (w_load || (w_fetch && !w_held)) r_err <= 1'b1;
                        if (!r_issued) begin
                            if (!core_busy) begin
                                r_final  <= 1'b1;
                                r_issued <= 1'b1;
                            end
                        end else if (core_dig_valid) begin
                            r_dig    <= core_digest;
                            r_odata  <= core_digest[DIGEST_W-1 -: IO_W];
                            r_idx    <= '0;
                            r_ack    <= 1'b1;
                            r_state  <= FETCH_OUT;
                            r_issued <= 1'b0;
                            r_hold   <= 1'b0;
                        end
                    end
                    FETCH_OUT: begin
                        if (w_load) begin
                            r_err <= 1'b1;
                        end else if (w_fetch) begin
                            r_idx   <= w_idx_nxt;
                            r_odata <= r_dig[w_idx_nxt];
                            r_ack   <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef HASH_IO_BRIDGE_BUSYCNT_EN
    logic [31:0] r_busy_cnt;

    // count core-busy cycles, saturating; an accepted init restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy_cnt <= '0;
        end else if (w_init) begin
            r_busy_cnt <= '0;
        end else if (core_busy && r_busy_cnt != 32'hFFFF_FFFF) begin
            r_busy_cnt <= r_busy_cnt + 32'd1;
        end
    end

    assign busy_cycles = r_busy_cnt;
`else
    assign busy_cycles = 32'd0;
`endif

    assign ack            = r_ack;
    assign err            = r_err;
    assign odata          = r_odata;
    assign core_init      = r_core_init;
    assign core_blk_valid = r_blk_valid;
    assign core_blk       = r_blk;
    assign core_final     = r_final;

endmodule
